// File: rtl/clk_div_bank.sv
// Bank of NUM_CH programmable 50%-duty clock dividers sharing one source clock.
// Ratio/enable changes are staged in a pending slot and applied only at a period boundary.
module clk_div_bank #(
  parameter  int NUM_CH = 4,
  parameter  int DIV_W  = 8,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic              cfg_en,
  input  logic              sync_in,
  output logic [NUM_CH-1:0] ch_clk_out,
  output logic [NUM_CH-1:0] ch_tick,
  output logic [NUM_CH-1:0] cfg_pend
);

  logic [NUM_CH-1:0] cfg_hit;

  // An out-of-range cfg_ch hits no channel, so it is always ready and simply dropped.
  assign cfg_ready = ~|(cfg_hit & cfg_pend);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [DIV_W-1:0] act_div_reg, act_div_next;
      logic [DIV_W-1:0] pnd_div_reg, pnd_div_next;
      logic [DIV_W-1:0] cnt_reg, cnt_next;
      logic             act_en_reg, act_en_next;
      logic             pnd_en_reg, pnd_en_next;
      logic             pend_reg, pend_next;
      logic             out_reg, out_next;
      logic             tick_reg, tick_next;
      logic             accept;
      logic             apply;
      logic             at_top;

      assign cfg_hit[gi] = (cfg_ch == CH_W'(gi));
      assign accept      = cfg_valid && cfg_hit[gi] && !pend_reg;
      assign at_top      = (cnt_reg == act_div_reg);

      always_comb begin
        act_div_next = act_div_reg;
        act_en_next  = act_en_reg;
        pnd_div_next = pnd_div_reg;
        pnd_en_next  = pnd_en_reg;
        pend_next    = pend_reg;
        cnt_next     = cnt_reg;
        out_next     = out_reg;
        apply        = 1'b0;

        if (sync_in || !act_en_reg) begin
          // Restart (or idle) from the start of a low phase, absorbing any staged config.
          apply    = pend_reg;
          cnt_next = '0;
          out_next = 1'b0;
        end else if (at_top) begin
          cnt_next = '0;
          if (out_reg) begin
            apply    = pend_reg;
            out_next = 1'b0;
          end else begin
            out_next = 1'b1;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end

        if (apply) begin
          act_div_next = pnd_div_reg;
          act_en_next  = pnd_en_reg;
          pend_next    = 1'b0;
        end

        // accept requires !pend_reg and apply requires pend_reg, so they never collide.
        if (accept) begin
          pnd_div_next = cfg_div;
          pnd_en_next  = cfg_en;
          pend_next    = 1'b1;
        end

        tick_next = out_next && !out_reg;
      end

      always_ff @(posedge clk_in) begin
        if (!rst_n) begin
          act_div_reg <= '0;
          act_en_reg  <= 1'b0;
          pnd_div_reg <= '0;
          pnd_en_reg  <= 1'b0;
          pend_reg    <= 1'b0;
          cnt_reg     <= '0;
          out_reg     <= 1'b0;
          tick_reg    <= 1'b0;
        end else begin
          act_div_reg <= act_div_next;
          act_en_reg  <= act_en_next;
          pnd_div_reg <= pnd_div_next;
          pnd_en_reg  <= pnd_en_next;
          pend_reg    <= pend_next;
          cnt_reg     <= cnt_next;
          out_reg     <= out_next;
          tick_reg    <= tick_next;
        end
      end

      assign ch_clk_out[gi] = out_reg;
      assign ch_tick[gi]    = tick_reg;
      assign cfg_pend[gi]   = pend_reg;
    end
  endgenerate

endmodule

// File: tb/tb_clk_div_bank.sv
// Scoreboard bench for clk_div_bank: expected per-cycle clk/tick/pend vectors are queued
// from the period formula when stimulus is issued, then popped and compared each cycle.
module tb_clk_div_bank;
  // Five channels so that cfg_ch=5 is representable yet out of range.
  localparam int NUM_CH = 5;
  localparam int DIV_W  = 8;
  localparam int CH_W   = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cfg_valid = 1'b0;
  logic              cfg_en = 1'b0;
  logic              sync_in = 1'b0;
  logic [CH_W-1:0]   cfg_ch = '0;
  logic [DIV_W-1:0]  cfg_div = '0;
  logic              cfg_ready;
  logic [NUM_CH-1:0] ch_clk_out, ch_tick, cfg_pend;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string             tag;
    logic [NUM_CH-1:0] mask;
    logic [NUM_CH-1:0] clk;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] pend;
  } exp_t;

  exp_t exp_q[$];

  clk_div_bank #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) dut (
    .clk_in    (clk),
    .rst_n     (rst_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_en    (cfg_en),
    .sync_in   (sync_in),
    .ch_clk_out(ch_clk_out),
    .ch_tick   (ch_tick),
    .cfg_pend  (cfg_pend)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Output level t cycles after a low phase starts, for half-period H+1.
  function automatic bit wclk(int t, int h);
    return (t % (2 * (h + 1))) >= (h + 1);
  endfunction

  function automatic bit wtick(int t, int h);
    return (t % (2 * (h + 1))) == (h + 1);
  endfunction

  function automatic void push(string tag, logic [NUM_CH-1:0] m, logic [NUM_CH-1:0] c,
                               logic [NUM_CH-1:0] t, logic [NUM_CH-1:0] p);
    exp_t e;
    e.tag = tag; e.mask = m; e.clk = c; e.tick = t; e.pend = p;
    exp_q.push_back(e);
  endfunction

  task automatic drive_cfg(int ch, int div, bit en);
    cfg_ch = CH_W'(ch); cfg_div = DIV_W'(div); cfg_en = en; cfg_valid = 1'b1;
    $display("cfg ch=%0d div=%0d en=%0d", ch, div, en);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sync_in = 1'b1;
    drive_cfg(1, 3, 1'b1);
    repeat (2) @(negedge clk);
    cfg_valid = 1'b0; sync_in = 1'b0; cfg_ch = '0;
    #1;
    total++;
    if ({ch_clk_out, ch_tick, cfg_pend} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got clk/tick/pend %b/%b/%b want all zero", ch_clk_out, ch_tick, cfg_pend);
    end
    total++;
    if (cfg_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready: got %b want 1", cfg_ready);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_div2();
    exp_t e;
    drive_cfg(0, 0, 1'b1);
    total++;
    if (cfg_ready !== 1'b1) begin
      bad++;
      $display("FAIL div2_ready: got %b want 1", cfg_ready);
    end
    push("div2", 5'b00001, '0, '0, 5'b00001);
    for (int c = 2; c <= 12; c++)
      push("div2", 5'b00001, {4'b0, wclk(c - 2, 0)}, {4'b0, wtick(c - 2, 0)}, '0);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      cfg_valid = 1'b0;
      e = exp_q.pop_front();
      total++;
      if ({ch_clk_out & e.mask, ch_tick & e.mask, cfg_pend & e.mask} !== {e.clk, e.tick, e.pend}) begin
        bad++;
        $display("FAIL %s cyc=%0d clk/tick/pend got %b/%b/%b want %b/%b/%b", e.tag, c,
                 ch_clk_out & e.mask, ch_tick & e.mask, cfg_pend & e.mask, e.clk, e.tick, e.pend);
      end
    end
  endtask

  task automatic test_ratio_change();
    exp_t e;
    drive_cfg(1, 3, 1'b1);
    push("ratio", 5'b00010, '0, '0, 5'b00010);
    for (int c = 2; c <= 21; c++) begin
      if (c <= 9)
        push("ratio", 5'b00010, {3'b0, wclk(c - 2, 3), 1'b0}, {3'b0, wtick(c - 2, 3), 1'b0},
             {3'b0, (c == 8 || c == 9), 1'b0});
      else
        push("ratio", 5'b00010, {3'b0, wclk(c - 10, 1), 1'b0}, {3'b0, wtick(c - 10, 1), 1'b0}, '0);
    end
    for (int c = 1; c <= 21; c++) begin
      @(negedge clk);
      cfg_valid = 1'b0;
      e = exp_q.pop_front();
      total++;
      if ({ch_clk_out & e.mask, ch_tick & e.mask, cfg_pend & e.mask} !== {e.clk, e.tick, e.pend}) begin
        bad++;
        $display("FAIL %s cyc=%0d clk/tick/pend got %b/%b/%b want %b/%b/%b", e.tag, c,
                 ch_clk_out & e.mask, ch_tick & e.mask, cfg_pend & e.mask, e.clk, e.tick, e.pend);
      end
      if (c == 7) begin
        drive_cfg(1, 1, 1'b1);
        total++;
        if (cfg_ready !== 1'b1) begin
          bad++;
          $display("FAIL ratio_ready_free: got %b want 1", cfg_ready);
        end
      end
      if (c == 8 || c == 9 || c == 10) begin
        cfg_ch = 3'd1;
        #1;
        total++;
        if (cfg_ready !== (c == 10)) begin
          bad++;
          $display("FAIL ratio_ready_pend cyc=%0d: got %b want %b", c, cfg_ready, (c == 10));
        end
      end
    end
  endtask

  task automatic test_disable();
    exp_t e;
    drive_cfg(2, 2, 1'b1);
    push("disable", 5'b00100, '0, '0, 5'b00100);
    for (int c = 2; c <= 24; c++) begin
      if (c <= 13)
        push("disable", 5'b00100, {2'b0, wclk(c - 2, 2), 2'b0}, {2'b0, wtick(c - 2, 2), 2'b0},
             {2'b0, (c >= 9), 2'b0});
      else
        push("disable", 5'b00100, '0, '0, '0);
    end
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      cfg_valid = 1'b0;
      e = exp_q.pop_front();
      total++;
      if ({ch_clk_out & e.mask, ch_tick & e.mask, cfg_pend & e.mask} !== {e.clk, e.tick, e.pend}) begin
        bad++;
        $display("FAIL %s cyc=%0d clk/tick/pend got %b/%b/%b want %b/%b/%b", e.tag, c,
                 ch_clk_out & e.mask, ch_tick & e.mask, cfg_pend & e.mask, e.clk, e.tick, e.pend);
      end
      if (c == 8) drive_cfg(2, 2, 1'b0);
    end
  endtask

  task automatic test_sync();
    exp_t e;
    drive_cfg(2, 2, 1'b1);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      cfg_valid = 1'b0;
    end
    // Sync restarts ch0..2 (H = channel index); ch3 is accepted in the same cycle.
    sync_in = 1'b1;
    drive_cfg(3, 0, 1'b1);
    for (int c = 8; c <= 23; c++) begin
      logic [NUM_CH-1:0] vc, vt, vp;
      vc = '0; vt = '0; vp = '0;
      for (int ch = 0; ch < 3; ch++) begin
        vc[ch] = wclk(c - 8, ch);
        vt[ch] = wtick(c - 8, ch);
      end
      if (c == 8) vp[3] = 1'b1;
      else begin
        vc[3] = wclk(c - 9, 0);
        vt[3] = wtick(c - 9, 0);
      end
      push("sync", '1, vc, vt, vp);
    end
    for (int c = 8; c <= 23; c++) begin
      @(negedge clk);
      sync_in = 1'b0;
      cfg_valid = 1'b0;
      e = exp_q.pop_front();
      total++;
      if ({ch_clk_out & e.mask, ch_tick & e.mask, cfg_pend & e.mask} !== {e.clk, e.tick, e.pend}) begin
        bad++;
        $display("FAIL %s cyc=%0d clk/tick/pend got %b/%b/%b want %b/%b/%b", e.tag, c,
                 ch_clk_out & e.mask, ch_tick & e.mask, cfg_pend & e.mask, e.clk, e.tick, e.pend);
      end
    end
  endtask

  task automatic test_max_div();
    exp_t e;
    int hi = 0;
    drive_cfg(4, 255, 1'b1);
    push("maxdiv", 5'b10000, '0, '0, 5'b10000);
    for (int c = 2; c <= 520; c++)
      push("maxdiv", 5'b10000, {wclk(c - 2, 255), 4'b0}, {wtick(c - 2, 255), 4'b0}, '0);
    for (int c = 1; c <= 520; c++) begin
      @(negedge clk);
      cfg_valid = 1'b0;
      e = exp_q.pop_front();
      total++;
      if ({ch_clk_out & e.mask, ch_tick & e.mask, cfg_pend & e.mask} !== {e.clk, e.tick, e.pend}) begin
        bad++;
        $display("FAIL %s cyc=%0d clk/tick/pend got %b/%b/%b want %b/%b/%b", e.tag, c,
                 ch_clk_out & e.mask, ch_tick & e.mask, cfg_pend & e.mask, e.clk, e.tick, e.pend);
      end
      if (c >= 2 && c <= 513 && ch_clk_out[4] === 1'b1) hi++;
      if (c == 100) begin
        drive_cfg(5, 7, 1'b1);
        total++;
        if (cfg_ready !== 1'b1) begin
          bad++;
          $display("FAIL oob_ready: got %b want 1", cfg_ready);
        end
      end
      if (c == 101) begin
        total++;
        if (cfg_pend !== '0) begin
          bad++;
          $display("FAIL oob_pend: got %b want 00000", cfg_pend);
        end
      end
    end
    total++;
    if (hi != 256) begin
      bad++;
      $display("FAIL maxdiv_high_count: got %0d want 256", hi);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int n = 0;
    while (!(ch_clk_out[4] === 1'b1 && ch_clk_out[0] === 1'b1) && n < 600) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (!(ch_clk_out[4] === 1'b1 && ch_clk_out[0] === 1'b1)) begin
      bad++;
      $display("FAIL rstmid_wait: got clk %b want ch0 and ch4 high within 600 cycles", ch_clk_out);
    end
    // Reset must win over a simultaneous sync and config request.
    rst_n = 1'b0;
    sync_in = 1'b1;
    drive_cfg(2, 1, 1'b1);
    for (int c = 1; c <= 20; c++) push("rstmid", '1, '0, '0, '0);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      rst_n = 1'b1; sync_in = 1'b0; cfg_valid = 1'b0;
      e = exp_q.pop_front();
      total++;
      if ({ch_clk_out & e.mask, ch_tick & e.mask, cfg_pend & e.mask} !== {e.clk, e.tick, e.pend}) begin
        bad++;
        $display("FAIL %s cyc=%0d clk/tick/pend got %b/%b/%b want %b/%b/%b", e.tag, c,
                 ch_clk_out & e.mask, ch_tick & e.mask, cfg_pend & e.mask, e.clk, e.tick, e.pend);
      end
      if (c == 1) begin
        total++;
        if (cfg_ready !== 1'b1) begin
          bad++;
          $display("FAIL rstmid_ready: got %b want 1", cfg_ready);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_div2();
    test_ratio_change();
    test_disable();
    test_sync();
    test_max_div();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
